// File: rtl/ifc_pkg.sv
// ifc_pkg: opcodes and FSM state encoding shared by the instruction fetch controller
package ifc_pkg;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_HALT = 6'h3F;
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, UPDATE, WAIT_PC, HALTED} state_e;
endpackage

// File: rtl/ifc_decode.sv
// ifc_decode: combinational decode of the control-flow fields of one instruction word
module ifc_decode
   import ifc_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
)(
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               zero_i,
   output logic               beq_o,
   output logic               jump_o,
   output logic [PC_W-1:0]    branch_offset_o,
   output logic [25:0]        jump_addr_o,
   output logic               is_halt_o
);
   logic [5:0] op;
   assign op              = instr_i[31:26];
   assign beq_o           = (op == OP_BEQ) & zero_i;
   assign jump_o          = op == OP_J;
   assign is_halt_o       = op == OP_HALT;
   assign branch_offset_o = {{(PC_W-16){instr_i[15]}}, instr_i[15:0]};
   assign jump_addr_o     = instr_i[25:0];
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch/decode sequencer driving pc_control_32.
// Optional imem_ack watchdog enabled by defining IFC_TIMEOUT_EN.
module instr_fetch_ctrl
   import ifc_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = 15
)(
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               run_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic               pc_finish_i,
   input  logic               zero_i,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   output logic               pc_start_o,
   output logic               beq_o,
   output logic               jump_o,
   output logic [PC_W-1:0]    branch_offset_o,
   output logic [25:0]        jump_addr_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               instr_valid_o,
   output logic               halted_o,
   output logic               err_o
);
   state_e             state_q, state_d;
   logic [PC_W-1:0]    addr_q, addr_d, off_q, off_d, dec_off;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [25:0]        ja_q, ja_d, dec_ja;
   logic               beq_q, beq_d, jump_q, jump_d, dec_beq, dec_jump, dec_halt;

   ifc_decode #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_decode (
      .instr_i         (instr_q),
      .zero_i          (zero_i),
      .beq_o           (dec_beq),
      .jump_o          (dec_jump),
      .branch_offset_o (dec_off),
      .jump_addr_o     (dec_ja),
      .is_halt_o       (dec_halt)
   );

`ifdef IFC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d, expired;
   // counter is zero on every FETCH entry because it clears outside FETCH
   assign cnt_d   = (state_q == FETCH) ? cnt_q + 1'b1 : '0;
   assign expired = cnt_q == CW'(TIMEOUT - 1);
   assign err_d   = err_q | (state_q == FETCH & ~imem_ack_i & expired);
   assign err_o   = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign err_o          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      beq_d   = beq_q;
      jump_d  = jump_q;
      off_d   = off_q;
      ja_d    = ja_q;
      case (state_q)
         IDLE: begin
            state_d = run_i ? FETCH : IDLE;
            addr_d  = run_i ? pc_i : addr_q;
         end
         FETCH: begin
            if (imem_ack_i) begin
               instr_d = imem_rdata_i;
               state_d = DECODE;
            end
`ifdef IFC_TIMEOUT_EN
            else if (expired) state_d = HALTED;
`endif
         end
         DECODE: begin
            beq_d   = dec_beq;
            jump_d  = dec_jump;
            off_d   = dec_off;
            ja_d    = dec_ja;
            state_d = dec_halt ? HALTED : UPDATE;
         end
         UPDATE: state_d = WAIT_PC;
         WAIT_PC: begin
            if (pc_finish_i) begin
               beq_d   = 1'b0;
               jump_d  = 1'b0;
               state_d = run_i ? FETCH : IDLE;
               addr_d  = run_i ? pc_i : addr_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         beq_q   <= 1'b0;
         jump_q  <= 1'b0;
         off_q   <= '0;
         ja_q    <= '0;
`ifdef IFC_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         beq_q   <= beq_d;
         jump_q  <= jump_d;
         off_q   <= off_d;
         ja_q    <= ja_d;
`ifdef IFC_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign imem_req_o      = state_q == FETCH;
   assign imem_addr_o     = addr_q;
   assign pc_start_o      = state_q == UPDATE;
   assign instr_valid_o   = state_q == DECODE;
   assign halted_o        = state_q == HALTED;
   assign beq_o           = beq_q;
   assign jump_o          = jump_q;
   assign branch_offset_o = off_q;
   assign jump_addr_o     = ja_q;
   assign instr_o         = instr_q;
endmodule
